// File: rtl/hs_arb_pkg.sv
// Shared types and defaults for the handshake arbiter.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN,
    GUARD_WAIT
  } state_t;

  localparam int GUARD_DEFAULT   = 4;
  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the search starts one past the last winner.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_arb.sv
// Round-robin arbiter feeding one payload at a time into a handshake synchronizer.
// Optional SEND abort timer enabled by defining HS_ARB_TIMEOUT_EN.
module handshake_arb
  import hs_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int GUARD   = GUARD_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic                  sready,
  output logic [WIDTH-1:0]      din,
  input  logic                  sidle,
  output logic                  busy,
  output logic                  err
);

  localparam int            PW         = $clog2(NREQ);
  localparam logic [3:0]    GUARD_LAST = 4'(GUARD - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   last_grant;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] winner;
  logic            arb_valid;
  logic            take;
  logic            timeout_hit;
  logic [3:0]      guard_cnt;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req    (req),
    .ptr    (last_grant),
    .winner (winner),
    .valid  (arb_valid)
  );

  always_comb begin
    win_idx  = last_grant;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        win_idx  = PW'(i);
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef HS_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] send_cnt;

  always_ff @(posedge clk) begin
    if (rst || state_q != SEND) send_cnt <= '0;
    else                        send_cnt <= send_cnt + 8'd1;
  end

  assign timeout_hit = (state_q == SEND) && !sidle && (send_cnt == TO_LAST);
  assign err         = timeout_hit && !rst;
`else
  // No abort path in this build: SEND waits for sidle and err is constant 0.
  assign timeout_hit = 1'b0;
  assign err         = (TIMEOUT == 0) && 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid && !rst) begin
          take    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (sidle || timeout_hit) state_d = DRAIN;
      end
      DRAIN: begin
        if (!sidle) state_d = GUARD_WAIT;
      end
      GUARD_WAIT: begin
        if (guard_cnt == GUARD_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      din        <= '0;
      guard_cnt  <= '0;
      last_grant <= PW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      if (take) begin
        din        <= sel_data;
        last_grant <= win_idx;
      end
      if (state_q == GUARD_WAIT) guard_cnt <= guard_cnt + 4'd1;
      else                       guard_cnt <= '0;
    end
  end

  assign grant  = take ? winner : '0;
  assign sready = (state_q == SEND);
  assign busy   = (state_q != IDLE);

endmodule

// File: doc/handshake_arb.md
HANDSHAKE_ARB -- requirements
Module: handshake_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the payload width.
REQ-002 SHALL have parameter NREQ, default 4, the number of requesters (2..8).
REQ-003 SHALL have parameter GUARD, default 4, the post-transfer quiet cycles (1..15).
REQ-004 SHALL have parameter TIMEOUT, default 255, the SEND abort limit in cycles (only used with HS_ARB_TIMEOUT_EN).
REQ-005 SHALL have port `clk  in  1` as the single source-domain clock; all logic is on its rising edge.
REQ-006 SHALL have port `rst  in  1` as the reset, synchronous and active-high.
REQ-007 SHALL have port `req  in  NREQ`: bit i is the request level from requester i.
REQ-008 SHALL have port `req_data  in  NREQ*WIDTH`: slice i carries requester i's payload and is stable while req[i]=1.
REQ-009 SHALL have port `grant  out  NREQ`: a one-hot, one-cycle pulse when a payload is accepted.
REQ-010 SHALL have port `sready  out  1`, driven to the handshake synchronizer's sready.
REQ-011 SHALL have port `din  out  WIDTH`, driven to the synchronizer's din.
REQ-012 SHALL have port `sidle  in  1`, returned from the synchronizer (sreq AND synchronized ack).
REQ-013 SHALL have port `busy  out  1`: high in any state other than IDLE.
REQ-014 SHALL have port `err  out  1`: a one-cycle pulse on timeout abort (0 when the macro is absent).

Function
REQ-015 SHALL implement the FSM IDLE -> SEND -> DRAIN -> GUARD_WAIT -> IDLE.
REQ-016 In IDLE with any req bit set, SHALL select a winner round-robin, starting at (last_grant+1) mod NREQ.
REQ-017 In the same cycle as selection, SHALL pulse grant[winner], latch the winner's req_data into din, and move to SEND.
REQ-018 With all req bits 0 in IDLE, SHALL stay in IDLE with no grant pulse.
REQ-019 In SEND, SHALL drive sready=1 and hold din constant.
REQ-020 On the first cycle sidle=1 in SEND, SHALL go to DRAIN.
REQ-021 In DRAIN, SHALL drive sready=0 and wait for sidle=0, then go to GUARD_WAIT.
REQ-022 In GUARD_WAIT, SHALL count GUARD cycles with a 4-bit counter, then return to IDLE.
REQ-023 Transfer acceptance latency SHALL be 0 cycles (grant in the cycle the req is seen in IDLE); sready SHALL rise on the next cycle.
REQ-024 The round-robin pointer SHALL update only on grant; it wraps from NREQ-1 to 0.
REQ-025 A req deasserted before grant SHALL be dropped, with no grant and no side effects.
REQ-026 A req held high after grant SHALL count as a new request in the next IDLE.
REQ-027 With all NREQ requesting continuously, grants SHALL rotate 0,1,2,...,NREQ-1,0 with no starvation.
REQ-028 If sidle is already 1 on SEND entry, SEND SHALL last exactly one cycle.
REQ-029 din SHALL change only on grant cycles.

Reset
REQ-030 With rst=1 at a clock edge, SHALL force IDLE, sready=0, din=0, grant=0, busy=0, err=0, guard counter=0, last_grant=NREQ-1 (so requester 0 wins first).
REQ-031 Reset mid-SEND SHALL drop sready on the following edge; the interrupted payload SHALL be discarded, not retried.

Configuration
REQ-032 With `HS_ARB_TIMEOUT_EN` defined, SHALL add an 8-bit SEND-cycle counter; on reaching TIMEOUT without sidle it SHALL pulse err and go to DRAIN.
REQ-033 Without `HS_ARB_TIMEOUT_EN`, SEND SHALL wait indefinitely for sidle, err SHALL be tied to 0, and no counter logic SHALL be present.

Structure
REQ-034 Package hs_arb_pkg SHALL hold the state enum (IDLE, SEND, DRAIN, GUARD_WAIT) and the GUARD/TIMEOUT defaults.
REQ-035 Sub-module rr_arbiter (request vector plus pointer in, one-hot winner plus valid out, combinational) SHALL contain the round-robin selection.
REQ-036 The FSM, counters and registers SHALL stay in handshake_arb.

Verification
REQ-037 Scenario: req=0001, data0=0xA5A5_0001; sidle rises 6 cycles after sready -> grant=0001 once, din=0xA5A5_0001, sready high 6 cycles, then IDLE after DRAIN + 4 GUARD cycles.
REQ-038 Scenario: req=1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, with one transfer per handshake.
REQ-039 Scenario: req[2] pulsed while busy and dropped before IDLE -> no grant to requester 2.
REQ-040 Scenario: rst=1 during SEND -> next cycle sready=0, busy=0, din=0; after release, req=0010 is granted first because requester 0 is idle.
REQ-041 Scenario: with HS_ARB_TIMEOUT_EN and TIMEOUT=16, sidle held 0 -> err pulse on SEND cycle 16, then DRAIN, GUARD_WAIT and IDLE.
REQ-042 Scenario: sidle=1 already on SEND entry -> sready high exactly 1 cycle.
